id_decode_unit: RTL and testbench
=================================

Name: id_decode_unit

Overview:
- Registered RV32I decode stage that replaces the combinational decoder plus the ID/EX register.
- Decodes one instruction per cycle and resolves operands through NUM_FWD prioritised forwarding ports.
- Detects load-use hazards and resolves branches and jumps in ID, issuing a registered redirect and squashing wrong-path fetches.
- Uses valid/ready handshakes on both sides, and exposes stall and redirect performance counters.

Parameters:
XLEN, 32, datapath width; supported values are 32 and 64.
NUM_FWD, 2, number of forwarding sources; slot 0 is the youngest and has the highest priority.
SQUASH_DEPTH, 1, number of accepted instructions discarded after each redirect (0-3).
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  clock.
rst  in  1  reset; asynchronous and active-low.
rdy  in  1  global enable; while low, all state is frozen.
flush_i  in  1  kill the in-flight output and reset squash_cnt.
in_valid_i  in  1  fetch holds a valid instruction.
in_ready_o  out  1  this unit accepts the instruction this cycle.
pc_i  in  XLEN  instruction address.
inst_i  in  32  instruction word.
reg1_addr_o, reg2_addr_o  out  5  register-file read addresses (combinational, taken from inst_i).
data1_i, data2_i  in  XLEN  register-file read data.
fwd_wreg_i  in  NUM_FWD  per-slot write enable.
fwd_wd_i  in  5*NUM_FWD  per-slot destination register.
fwd_wdata_i  in  XLEN*NUM_FWD  per-slot result.
fwd_is_load_i  in  NUM_FWD  the slot's result is not yet available (load in flight).
out_valid_o  out  1  decoded bundle is valid.
out_ready_i  in  1  downstream consumes the bundle.
opcode_o  out  7  decoded opcode.
func3_o  out  3  decoded func3.
func7_o  out  7  decoded func7.
data1_o, data2_o  out  XLEN  resolved operands or immediate.
ls_offset_o  out  XLEN  load/store offset.
wd_o  out  5  destination register.
wreg_o  out  1  destination write enable.
illegal_o  out  1  bundle carries an undecodable instruction.
redirect_o  out  1  one-cycle redirect pulse.
redirect_addr_o  out  XLEN  redirect target.
stall_cnt_o  out  CNT_W  saturating count of load-use stall cycles.
redirect_cnt_o  out  CNT_W  saturating count of redirects.

Behaviour:
- Reset (rst low, asynchronous): all registered outputs are 0, including out_valid_o, redirect_o, both counters, and squash_cnt.
- Operand resolution, per source reg, in priority order:
  - read disabled -> immediate (LUI imm; AUIPC pc+imm; JAL/JALR pc+4; I-type sign-extended imm; shifts zero-extended shamt).
  - x0 -> 0.
  - lowest-index matching fwd slot with fwd_wreg_i set -> that slot's fwd_wdata_i.
  - otherwise -> data*_i.
- Hazard: the matching slot has fwd_is_load_i set.
- in_ready_o = rdy & !hazard & (!out_valid_o | out_ready_i). The bundle is a register stage with latency 1.
- A hazard cycle with in_valid_i high increments stall_cnt_o and presents no new bundle: out_valid_o drops if the previous bundle was consumed.
- Accept (in_valid_i & in_ready_o):
  - squash_cnt>0 -> discard the instruction, decrement squash_cnt, out_valid_o <= 0.
  - otherwise -> register the bundle and set out_valid_o.
- Without an accept, when out_ready_i is high, out_valid_o <= 0; all other bundle fields hold.
- Branches (BEQ, BNE, BLT, BGE, BLTU, BGEU): BLT/BGE use a true signed compare; BLTU/BGEU unsigned. Target = pc + sign-extended B-imm.
- JAL target = pc + J-imm. JALR target = (rs1 + I-imm) with bit 0 cleared.
- Taken branch or jump accepted (not squashed): next cycle redirect_o=1 for exactly one cycle with redirect_addr_o; squash_cnt <= SQUASH_DEPTH; redirect_cnt_o increments. Not-taken branches produce no redirect.
- Unknown opcode: out_valid_o set, illegal_o=1, wreg_o=0, no redirect.
- inst_i == 0: bubble; accepted, but out_valid_o <= 0.
- flush_i: next cycle out_valid_o=0, redirect_o=0, squash_cnt=0, and no accept that cycle. flush_i wins over a simultaneous redirect.
- rdy low: every register holds, including redirect_o.
- Counters saturate at all-ones.
- Arithmetic wraps modulo 2^XLEN.
- Reset asserted mid-stall or mid-squash clears everything immediately.

Test Plan:
- Directed ADDI: x1=5, ADDI x2,x1,-3 with no forwarding -> one cycle later out_valid_o=1, data1_o=5, data2_o=0xFFFFFFFD, wd_o=2, wreg_o=1.
- Forwarding priority: slot0 (wd=3, data 0x11) and slot1 (wd=3, data 0x22) both match; ADD x4,x3,x0 -> data1_o=0x11, data2_o=0.
- Load-use: slot0 wd=5, is_load=1; ADD x6,x5,x5 held for 2 cycles -> in_ready_o=0 for 2 cycles, stall_cnt_o=2; the instruction is accepted when is_load drops.
- Signed vs unsigned branches: BLT with x1=0xFFFFFFFF, x2=1 at pc=0x100, imm=+16 -> redirect_o pulse with redirect_addr_o=0x110; the next accepted instruction is discarded, redirect_cnt_o=1. BLTU with the same operands -> no redirect.
- JALR x1, x2, 3 with x2=0x200 -> redirect_addr_o=0x202, data1_o=pc+4.
- Backpressure and flush: out_ready_i=0 for 3 cycles -> bundle stable, in_ready_o=0. flush_i plus a simultaneous taken branch -> out_valid_o=0, redirect_o=0 next cycle. Reset asserted mid-squash -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/id_decode_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : id_decode_unit                                               |
// | Description : Registered RV32I decode stage. Decodes one instruction per   |
// |               cycle, resolves operands through prioritised forwarding      |
// |               slots, stalls on load-use hazards, and resolves branches and |
// |               jumps in ID with a registered one-cycle redirect pulse that  |
// |               squashes the following wrong-path fetches.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, rst            clock; asynchronous active-low reset                 |
// |   rdy                 global enable, all state frozen while low            |
// |   flush_i             kill in-flight bundle and pending squash             |
// |   in_valid_i/ready_o  fetch-side handshake, pc_i / inst_i payload          |
// |   reg1/2_addr_o       register-file read addresses (combinational)         |
// |   data1_i/data2_i     register-file read data                              |
// |   fwd_*_i             forwarding slots, slot 0 youngest / highest priority |
// |   out_valid_o/ready_i execute-side handshake                               |
// |   opcode/func3/func7/data1/data2/ls_offset/wd/wreg/illegal  bundle fields  |
// |   redirect_o/addr_o   one-cycle redirect pulse and target                  |
// |   stall_cnt_o         saturating load-use stall cycle count                |
// |   redirect_cnt_o      saturating redirect count                            |
// +----------------------------------------------------------------------------+
module id_decode_unit #(
  parameter int XLEN         = 32,
  parameter int NUM_FWD      = 2,
  parameter int SQUASH_DEPTH = 1,
  parameter int CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [XLEN-1:0]         pc_i,
  input  logic [31:0]             inst_i,
  output logic [4:0]              reg1_addr_o,
  output logic [4:0]              reg2_addr_o,
  input  logic [XLEN-1:0]         data1_i,
  input  logic [XLEN-1:0]         data2_i,
  input  logic [NUM_FWD-1:0]      fwd_wreg_i,
  input  logic [5*NUM_FWD-1:0]    fwd_wd_i,
  input  logic [XLEN*NUM_FWD-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]      fwd_is_load_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [6:0]              opcode_o,
  output logic [2:0]              func3_o,
  output logic [6:0]              func7_o,
  output logic [XLEN-1:0]         data1_o,
  output logic [XLEN-1:0]         data2_o,
  output logic [XLEN-1:0]         ls_offset_o,
  output logic [4:0]              wd_o,
  output logic                    wreg_o,
  output logic                    illegal_o,
  output logic                    redirect_o,
  output logic [XLEN-1:0]         redirect_addr_o,
  output logic [CNT_W-1:0]        stall_cnt_o,
  output logic [CNT_W-1:0]        redirect_cnt_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int             SHAMT_W     = (XLEN == 64) ? 6 : 5;
  localparam logic [1:0]     SQUASH_INIT = 2'(SQUASH_DEPTH);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  // Returns {load_pending, value} for one source register. The loop runs
  // from the oldest slot down so the youngest matching slot wins.
  function automatic logic [XLEN:0] resolve(
    input logic [4:0]              rs,
    input logic [XLEN-1:0]         rf,
    input logic [NUM_FWD-1:0]      wreg,
    input logic [5*NUM_FWD-1:0]    wd,
    input logic [XLEN*NUM_FWD-1:0] wdata,
    input logic [NUM_FWD-1:0]      ld
  );
    logic [XLEN:0] r;
    r = {1'b0, rf};
    if (rs == 5'd0) begin
      r = '0;
    end else begin
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (wreg[k] && (wd[k*5 +: 5] == rs)) begin
          r = {ld[k], wdata[k*XLEN +: XLEN]};
        end
      end
    end
    return r;
  endfunction

  logic [6:0]        op;
  logic [2:0]        f3;
  logic              rd1_en;
  logic              rd2_en;
  logic              writes;
  logic              known;
  logic signed [31:0] imm_i32;
  logic signed [31:0] imm_s32;
  logic signed [31:0] imm_b32;
  logic signed [31:0] imm_u32;
  logic signed [31:0] imm_j32;
  logic [XLEN-1:0]   imm_i;
  logic [XLEN-1:0]   imm_s;
  logic [XLEN-1:0]   imm_b;
  logic [XLEN-1:0]   imm_u;
  logic [XLEN-1:0]   imm_j;
  logic [XLEN:0]     rs1_res;
  logic [XLEN:0]     rs2_res;
  logic [XLEN-1:0]   rs1_val;
  logic [XLEN-1:0]   rs2_val;
  logic              hazard;
  logic              taken;
  logic              redirect_d;
  logic [XLEN-1:0]   target_d;
  logic [XLEN-1:0]   data1_d;
  logic [XLEN-1:0]   data2_d;
  logic [XLEN-1:0]   ls_offset_d;
  logic              accept;
  logic [1:0]        squash_cnt;

  assign reg1_addr_o = inst_i[19:15];
  assign reg2_addr_o = inst_i[24:20];

  always_comb begin
    op     = inst_i[6:0];
    f3     = inst_i[14:12];
    rd1_en = 1'b0;
    rd2_en = 1'b0;
    writes = 1'b0;
    known  = 1'b1;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL: writes = 1'b1;
      OP_JALR:   begin rd1_en = 1'b1; writes = 1'b1; end
      OP_BRANCH: begin rd1_en = 1'b1; rd2_en = 1'b1; end
      OP_LOAD:   begin rd1_en = 1'b1; writes = 1'b1; end
      OP_STORE:  begin rd1_en = 1'b1; rd2_en = 1'b1; end
      OP_IMM:    begin rd1_en = 1'b1; writes = 1'b1; end
      OP_REG:    begin rd1_en = 1'b1; rd2_en = 1'b1; writes = 1'b1; end
      OP_FENCE, OP_SYSTEM: known = 1'b1;
      default:   known = 1'b0;
    endcase
  end

  // Immediates are formed at 32 bits and sign-extended to XLEN by the cast.
  always_comb begin
    imm_i32 = {{20{inst_i[31]}}, inst_i[31:20]};
    imm_s32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    imm_b32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    imm_u32 = {inst_i[31:12], 12'b0};
    imm_j32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    imm_i   = XLEN'(imm_i32);
    imm_s   = XLEN'(imm_s32);
    imm_b   = XLEN'(imm_b32);
    imm_u   = XLEN'(imm_u32);
    imm_j   = XLEN'(imm_j32);
  end

  always_comb begin
    rs1_res = resolve(inst_i[19:15], data1_i, fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_is_load_i);
    rs2_res = resolve(inst_i[24:20], data2_i, fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_is_load_i);
    rs1_val = rs1_res[XLEN-1:0];
    rs2_val = rs2_res[XLEN-1:0];
    // Only an operand that is actually read can stall on an in-flight load.
    hazard  = (rd1_en & rs1_res[XLEN]) | (rd2_en & rs2_res[XLEN]);
  end

  always_comb begin
    case (f3)
      3'b000:  taken = (rs1_val == rs2_val);
      3'b001:  taken = (rs1_val != rs2_val);
      3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  taken = (rs1_val <  rs2_val);
      3'b111:  taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase

    redirect_d = 1'b0;
    target_d   = pc_i + imm_b;
    case (op)
      OP_BRANCH: redirect_d = taken;
      OP_JAL:    begin redirect_d = 1'b1; target_d = pc_i + imm_j; end
      OP_JALR:   begin redirect_d = 1'b1; target_d = (rs1_val + imm_i) & ALIGN_MASK; end
      default:   redirect_d = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      OP_LUI:           data1_d = imm_u;
      OP_AUIPC:         data1_d = pc_i + imm_u;
      OP_JAL, OP_JALR:  data1_d = pc_i + XLEN'(4);
      default:          data1_d = rd1_en ? rs1_val : '0;
    endcase

    case (op)
      OP_IMM:           data2_d = (f3[1:0] == 2'b01) ? XLEN'(inst_i[20 +: SHAMT_W]) : imm_i;
      OP_LOAD, OP_JALR: data2_d = imm_i;
      default:          data2_d = rd2_en ? rs2_val : '0;
    endcase

    case (op)
      OP_LOAD:  ls_offset_d = imm_i;
      OP_STORE: ls_offset_d = imm_s;
      default:  ls_offset_d = '0;
    endcase
  end

  assign in_ready_o = rdy & ~hazard & (~out_valid_o | out_ready_i);
  assign accept     = in_valid_i & in_ready_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_o     <= 1'b0;
      opcode_o        <= '0;
      func3_o         <= '0;
      func7_o         <= '0;
      data1_o         <= '0;
      data2_o         <= '0;
      ls_offset_o     <= '0;
      wd_o            <= '0;
      wreg_o          <= 1'b0;
      illegal_o       <= 1'b0;
      redirect_o      <= 1'b0;
      redirect_addr_o <= '0;
      stall_cnt_o     <= '0;
      redirect_cnt_o  <= '0;
      squash_cnt      <= '0;
    end else if (rdy) begin
      redirect_o <= 1'b0;

      if (in_valid_i && hazard && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end

      if (flush_i) begin
        // Flush overrides any accept, including a taken branch this cycle.
        out_valid_o <= 1'b0;
        squash_cnt  <= '0;
      end else if (accept) begin
        if (squash_cnt != 2'd0) begin
          squash_cnt  <= squash_cnt - 2'd1;
          out_valid_o <= 1'b0;
        end else if (inst_i == 32'd0) begin
          out_valid_o <= 1'b0;
        end else begin
          out_valid_o <= 1'b1;
          opcode_o    <= op;
          func3_o     <= f3;
          func7_o     <= inst_i[31:25];
          data1_o     <= data1_d;
          data2_o     <= data2_d;
          ls_offset_o <= ls_offset_d;
          wd_o        <= inst_i[11:7];
          wreg_o      <= writes;
          illegal_o   <= ~known;
          if (redirect_d) begin
            redirect_o      <= 1'b1;
            redirect_addr_o <= target_d;
            squash_cnt      <= SQUASH_INIT;
            if (redirect_cnt_o != '1) begin
              redirect_cnt_o <= redirect_cnt_o + CNT_W'(1);
            end
          end
        end
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_decode_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_id_decode_unit                                            |
// | Description : Directed self-checking bench for id_decode_unit. Counters    |
// |               are built 2 bits wide so saturation is reachable.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_id_decode_unit;

  localparam int XLEN    = 32;
  localparam int NUM_FWD = 2;
  localparam int CNT_W   = 2;

  localparam logic [31:0] I_ADDI = 32'hFFD08113; // addi x2, x1, -3
  localparam logic [31:0] I_ADD4 = 32'h00018233; // add  x4, x3, x0
  localparam logic [31:0] I_ADD6 = 32'h00528333; // add  x6, x5, x5
  localparam logic [31:0] I_BLT  = 32'h0020C863; // blt  x1, x2, +16
  localparam logic [31:0] I_BLTU = 32'h0020E863; // bltu x1, x2, +16
  localparam logic [31:0] I_JALR = 32'h003100E7; // jalr x1, x2, 3
  localparam logic [31:0] I_LUI  = 32'h123452B7; // lui  x5, 0x12345
  localparam logic [31:0] I_SRAI = 32'h4070D193; // srai x3, x1, 7
  localparam logic [31:0] I_BAD  = 32'h0000007F; // unknown opcode

  logic clk, rst, rdy, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [XLEN-1:0] pc_i, data1_i, data2_i, data1_o, data2_o, ls_offset_o, redirect_addr_o;
  logic [31:0] inst_i;
  logic [4:0] reg1_addr_o, reg2_addr_o, wd_o;
  logic [NUM_FWD-1:0] fwd_wreg_i, fwd_is_load_i;
  logic [5*NUM_FWD-1:0] fwd_wd_i;
  logic [XLEN*NUM_FWD-1:0] fwd_wdata_i;
  logic [6:0] opcode_o, func7_o;
  logic [2:0] func3_o;
  logic wreg_o, illegal_o, redirect_o;
  logic [CNT_W-1:0] stall_cnt_o, redirect_cnt_o;

  int n_assert = 0;
  int n_fail   = 0;

  id_decode_unit #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .SQUASH_DEPTH(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .pc_i(pc_i), .inst_i(inst_i),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .data1_i(data1_i), .data2_i(data2_i),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
    .fwd_is_load_i(fwd_is_load_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .opcode_o(opcode_o), .func3_o(func3_o), .func7_o(func7_o),
    .data1_o(data1_o), .data2_o(data2_o), .ls_offset_o(ls_offset_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .illegal_o(illegal_o),
    .redirect_o(redirect_o), .redirect_addr_o(redirect_addr_o),
    .stall_cnt_o(stall_cnt_o), .redirect_cnt_o(redirect_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    pc_i = '0; inst_i = '0; data1_i = '0; data2_i = '0;
    fwd_wreg_i = '0; fwd_wd_i = '0; fwd_wdata_i = '0; fwd_is_load_i = '0;
    step(); step();
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_redirect", redirect_o, 0);
    chk("rst_stall_cnt", stall_cnt_o, 0);
    chk("rst_redirect_cnt", redirect_cnt_o, 0);
    chk("rst_data1", data1_o, 0);
    rst = 1'b1;

    // ADDI x2,x1,-3 with x1=5
    pc_i = 32'h0; inst_i = I_ADDI; data1_i = 32'd5; data2_i = 32'hDEAD; in_valid_i = 1'b1;
    #1;
    chk("addi_reg1_addr", reg1_addr_o, 1);
    chk("addi_in_ready", in_ready_o, 1);
    step();
    chk("addi_valid", out_valid_o, 1);
    chk("addi_data1", data1_o, 32'd5);
    chk("addi_data2", data2_o, 32'hFFFFFFFD);
    chk("addi_wd", wd_o, 2);
    chk("addi_wreg", wreg_o, 1);
    chk("addi_opcode", opcode_o, 7'h13);

    // Forwarding priority: both slots match x3, slot 0 wins
    fwd_wreg_i = 2'b11; fwd_wd_i = {5'd3, 5'd3}; fwd_wdata_i = {32'h22, 32'h11};
    inst_i = I_ADD4; data1_i = 32'h99; data2_i = 32'h77;
    step();
    chk("fwd_prio_data1", data1_o, 32'h11);
    chk("fwd_prio_data2", data2_o, 0);
    chk("fwd_prio_wd", wd_o, 4);
    fwd_wreg_i = 2'b10;
    step();
    chk("fwd_slot1_data1", data1_o, 32'h22);

    // Load-use hazard on x5 for two cycles
    fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd5}; fwd_wdata_i = {32'h0, 32'h55};
    fwd_is_load_i = 2'b01; inst_i = I_ADD6;
    #1;
    chk("lu_in_ready_0", in_ready_o, 0);
    step();
    chk("lu_valid_drop", out_valid_o, 0);
    chk("lu_stall_1", stall_cnt_o, 1);
    chk("lu_in_ready_1", in_ready_o, 0);
    step();
    chk("lu_stall_2", stall_cnt_o, 2);
    fwd_is_load_i = 2'b00;
    #1;
    chk("lu_in_ready_release", in_ready_o, 1);
    step();
    chk("lu_accept_valid", out_valid_o, 1);
    chk("lu_data1", data1_o, 32'h55);
    chk("lu_data2", data2_o, 32'h55);
    chk("lu_wd", wd_o, 6);
    chk("lu_stall_hold", stall_cnt_o, 2);
    // Stall counter saturates at 3 with a 2-bit width
    fwd_is_load_i = 2'b01;
    step();
    chk("stall_sat_3", stall_cnt_o, 3);
    step();
    chk("stall_sat_hold", stall_cnt_o, 3);
    fwd_is_load_i = 2'b00; fwd_wreg_i = 2'b00;

    // BLT taken: -1 < 1 signed
    pc_i = 32'h100; inst_i = I_BLT; data1_i = 32'hFFFFFFFF; data2_i = 32'd1;
    step();
    chk("blt_redirect", redirect_o, 1);
    chk("blt_target", redirect_addr_o, 32'h110);
    chk("blt_redirect_cnt", redirect_cnt_o, 1);
    chk("blt_valid", out_valid_o, 1);
    pc_i = 32'h104; inst_i = I_ADDI; data1_i = 32'hA;
    step();
    chk("blt_pulse_end", redirect_o, 0);
    chk("blt_squashed", out_valid_o, 0);
    pc_i = 32'h110; data1_i = 32'd7;
    step();
    chk("post_squash_valid", out_valid_o, 1);
    chk("post_squash_data1", data1_o, 32'd7);

    // BLTU not taken: 0xFFFFFFFF < 1 unsigned is false
    pc_i = 32'h120; inst_i = I_BLTU; data1_i = 32'hFFFFFFFF; data2_i = 32'd1;
    step();
    chk("bltu_no_redirect", redirect_o, 0);
    chk("bltu_valid", out_valid_o, 1);
    chk("bltu_redirect_cnt", redirect_cnt_o, 1);
    pc_i = 32'h124; inst_i = I_ADDI; data1_i = 32'd9;
    step();
    chk("bltu_next_kept", out_valid_o, 1);
    chk("bltu_next_data1", data1_o, 32'd9);

    // JALR x1, x2, 3 with x2=0x200
    pc_i = 32'h300; inst_i = I_JALR; data1_i = 32'h200;
    #1;
    chk("jalr_reg1_addr", reg1_addr_o, 2);
    step();
    chk("jalr_redirect", redirect_o, 1);
    chk("jalr_target", redirect_addr_o, 32'h202);
    chk("jalr_link", data1_o, 32'h304);
    chk("jalr_wd", wd_o, 1);
    chk("jalr_redirect_cnt", redirect_cnt_o, 2);
    // rdy low freezes everything, including the redirect pulse
    rdy = 1'b0; in_valid_i = 1'b0;
    #1;
    chk("rdy_low_in_ready", in_ready_o, 0);
    step();
    chk("rdy_low_redirect_held", redirect_o, 1);
    chk("rdy_low_valid_held", out_valid_o, 1);
    rdy = 1'b1; in_valid_i = 1'b1; pc_i = 32'h304; inst_i = I_ADDI; data1_i = 32'd1;
    step();
    chk("jalr_pulse_end", redirect_o, 0);
    chk("jalr_squashed", out_valid_o, 0);

    // Backpressure for three cycles
    pc_i = 32'h400; inst_i = I_ADDI; data1_i = 32'h10;
    step();
    chk("bp_valid", out_valid_o, 1);
    out_ready_i = 1'b0; pc_i = 32'h404; inst_i = I_LUI;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", in_ready_o, 0);
      step();
      chk("bp_valid_hold", out_valid_o, 1);
      chk("bp_data1_hold", data1_o, 32'h10);
    end
    out_ready_i = 1'b1;
    #1;
    chk("bp_release_ready", in_ready_o, 1);
    step();
    chk("lui_data1", data1_o, 32'h12345000);
    chk("lui_wd", wd_o, 5);

    // Shift immediate is zero-extended shamt, not the full I-imm
    inst_i = I_SRAI; data1_i = 32'hAB;
    step();
    chk("srai_data1", data1_o, 32'hAB);
    chk("srai_data2", data2_o, 32'd7);
    chk("srai_func7", func7_o, 7'h20);
    chk("srai_func3", func3_o, 3'd5);

    // Unknown opcode
    inst_i = I_BAD;
    step();
    chk("bad_valid", out_valid_o, 1);
    chk("bad_illegal", illegal_o, 1);
    chk("bad_wreg", wreg_o, 0);
    chk("bad_redirect", redirect_o, 0);

    // All-zero instruction is a bubble
    inst_i = 32'h0;
    step();
    chk("bubble_valid", out_valid_o, 0);

    // Flush with a simultaneous taken branch
    pc_i = 32'h500; inst_i = I_BLT; data1_i = 32'hFFFFFFFF; data2_i = 32'd1; flush_i = 1'b1;
    step();
    chk("flush_valid", out_valid_o, 0);
    chk("flush_redirect", redirect_o, 0);
    chk("flush_redirect_cnt", redirect_cnt_o, 2);
    flush_i = 1'b0; pc_i = 32'h510;
    step();
    chk("blt2_redirect", redirect_o, 1);
    chk("blt2_redirect_cnt", redirect_cnt_o, 3);
    // Flush also clears the pending squash
    flush_i = 1'b1; in_valid_i = 1'b0;
    step();
    chk("flush2_valid", out_valid_o, 0);
    flush_i = 1'b0; in_valid_i = 1'b1; inst_i = I_ADDI; data1_i = 32'd3;
    step();
    chk("flush_cleared_squash", out_valid_o, 1);
    chk("flush_cleared_data1", data1_o, 32'd3);

    // Redirect counter saturates, then reset mid-squash
    pc_i = 32'h600; inst_i = I_BLT; data1_i = 32'hFFFFFFFF; data2_i = 32'd1;
    step();
    chk("blt3_redirect", redirect_o, 1);
    chk("redirect_cnt_sat", redirect_cnt_o, 3);
    in_valid_i = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", out_valid_o, 0);
    chk("async_rst_redirect", redirect_o, 0);
    chk("async_rst_redirect_cnt", redirect_cnt_o, 0);
    chk("async_rst_stall_cnt", stall_cnt_o, 0);
    chk("async_rst_data1", data1_o, 0);
    chk("async_rst_target", redirect_addr_o, 0);
    #1;
    rst = 1'b1;
    in_valid_i = 1'b1; inst_i = I_ADDI; data1_i = 32'd4;
    step();
    chk("post_rst_valid", out_valid_o, 1);
    chk("post_rst_data1", data1_o, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
